// File: rtl/game_pkg.sv
// Shared maze-game definitions: session state encoding and BCD digit type,
// used by the flow controller and the screen/LED/voice/7-seg blocks.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_GAME  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4,
    ST_PAUSE = 3'd5
  } game_state_e;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_down_timer.sv
// Min:sec BCD countdown. Loads a start value, decrements once per enable and
// stops at 0:00 instead of wrapping.
module bcd_down_timer
  import game_pkg::*;
#(
  parameter int RST_MIN = 4,
  parameter int RST_SEC = 44
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  input  bcd_t ld_min_i,
  input  bcd_t ld_sec10_i,
  input  bcd_t ld_sec1_i,
  output bcd_t min_o,
  output bcd_t sec10_o,
  output bcd_t sec1_o,
  output logic zero_o
);

  localparam bcd_t RST_MIN_D   = 4'(RST_MIN);
  localparam bcd_t RST_SEC10_D = 4'(RST_SEC / 10);
  localparam bcd_t RST_SEC1_D  = 4'(RST_SEC % 10);

  bcd_t min_q, min_d;
  bcd_t sec10_q, sec10_d;
  bcd_t sec1_q, sec1_d;
  logic zero;

  assign zero = (min_q == 4'd0) && (sec10_q == 4'd0) && (sec1_q == 4'd0);

  always_comb begin
    min_d   = min_q;
    sec10_d = sec10_q;
    sec1_d  = sec1_q;
    if (load_i) begin
      min_d   = ld_min_i;
      sec10_d = ld_sec10_i;
      sec1_d  = ld_sec1_i;
    end else if (en_i && !zero) begin
      // Not at 0:00, so a double borrow always finds a nonzero minute digit.
      if (sec1_q != 4'd0) begin
        sec1_d = sec1_q - 4'd1;
      end else begin
        sec1_d = 4'd9;
        if (sec10_q != 4'd0) begin
          sec10_d = sec10_q - 4'd1;
        end else begin
          sec10_d = 4'd5;
          min_d   = min_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q   <= RST_MIN_D;
      sec10_q <= RST_SEC10_D;
      sec1_q  <= RST_SEC1_D;
    end else begin
      min_q   <= min_d;
      sec10_q <= sec10_d;
      sec1_q  <= sec1_d;
    end
  end

  assign min_o   = min_q;
  assign sec10_o = sec10_q;
  assign sec1_o  = sec1_q;
  assign zero_o  = zero;

endmodule

// File: rtl/game_flow_ctrl.sv
// Maze-game session controller: state machine, seconds prescaler, pre-level
// wait countdown, hit points, level progression and the per-level timer.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int START_MIN  = 4,
  parameter int START_SEC  = 44,
  parameter int WAIT_SEC   = 3,
  parameter int MAX_HP     = 3,
  parameter int HP_W       = 3,
  parameter int NUM_LEVELS = 3,
  parameter int LVL_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             goal,
  input  logic             damage,
  input  logic             heal,
  output logic [2:0]       state,
  output logic [LVL_W-1:0] level,
  output logic [HP_W-1:0]  hp,
  output logic [3:0]       t_min,
  output logic [3:0]       t_sec10,
  output logic [3:0]       t_sec1,
  output logic [3:0]       wait_left,
  output logic             sec_tick
);

  localparam int              PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PMAX     = PW'(TICK_DIV - 1);
  localparam logic [HP_W-1:0] HP_MAX   = HP_W'(MAX_HP);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(NUM_LEVELS - 1);
  localparam logic [3:0]      WAIT_LD  = 4'(WAIT_SEC);
  localparam bcd_t            LD_MIN   = 4'(START_MIN);
  localparam bcd_t            LD_SEC10 = 4'(START_SEC / 10);
  localparam bcd_t            LD_SEC1  = 4'(START_SEC % 10);

  game_state_e      state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [3:0]       wait_q, wait_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             sec_tick_q;

  logic          tick;
  logic          tmr_load;
  logic          tmr_en;
  logic          tmr_zero;
  logic [PW-1:0] presc_run;

  assign presc_run = (presc_q == PMAX) ? '0 : presc_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    hp_d     = hp_q;
    wait_d   = wait_q;
    tmr_load = 1'b0;
    tick     = 1'b0;

    case (state_q)
      ST_INIT, ST_WIN, ST_LOSE: begin
        if (start) begin
          state_d = ST_WAIT;
          level_d = '0;
          hp_d    = HP_MAX;
        end
      end
      ST_WAIT: begin
        if (presc_q == PMAX) begin
          tick = 1'b1;
          if (wait_q <= 4'd1) begin
            state_d = ST_GAME;
            wait_d  = 4'd0;
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
      end
      ST_GAME: begin
        // A goal consumes the cycle: hp changes sampled alongside it are dropped.
        if (goal) begin
          if (level_q == LVL_LAST) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_WAIT;
            level_d = level_q + 1'b1;
          end
        end else begin
          if (damage && !heal && hp_q != '0) begin
            hp_d = hp_q - 1'b1;
          end else if (heal && !damage && hp_q != HP_MAX) begin
            hp_d = hp_q + 1'b1;
          end
          if (hp_q == '0 || tmr_zero) begin
            state_d = ST_LOSE;
          end else if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            tick = (presc_q == PMAX);
          end
        end
      end
      ST_PAUSE: begin
        if (pause) begin
          state_d = ST_GAME;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (state_d == ST_WAIT && state_q != ST_WAIT) begin
      tmr_load = 1'b1;
      wait_d   = WAIT_LD;
    end

    // Entering or leaving PAUSE keeps the partial second; any other entry restarts it.
    if (state_d != state_q) begin
      presc_d = (state_d == ST_PAUSE || state_q == ST_PAUSE) ? presc_q : '0;
    end else if (state_q == ST_WAIT || state_q == ST_GAME) begin
      presc_d = presc_run;
    end else if (state_q == ST_PAUSE) begin
      presc_d = presc_q;
    end else begin
      presc_d = '0;
    end
  end

  assign tmr_en = tick && (state_q == ST_GAME);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      level_q    <= '0;
      hp_q       <= HP_MAX;
      wait_q     <= WAIT_LD;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      hp_q       <= hp_d;
      wait_q     <= wait_d;
      presc_q    <= presc_d;
      sec_tick_q <= tick;
    end
  end

  bcd_down_timer #(
    .RST_MIN (START_MIN),
    .RST_SEC (START_SEC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .ld_min_i   (LD_MIN),
    .ld_sec10_i (LD_SEC10),
    .ld_sec1_i  (LD_SEC1),
    .min_o      (t_min),
    .sec10_o    (t_sec10),
    .sec1_o     (t_sec1),
    .zero_o     (tmr_zero)
  );

  assign state     = state_q;
  assign level     = level_q;
  assign hp        = hp_q;
  assign wait_left = wait_q;
  assign sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a two-level instance with a 4-cycle
// second, and a 1:10 / 1-second-wait instance exercising BCD borrows and time-out.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       st0 = 0, pa0 = 0, go0 = 0, dm0 = 0, he0 = 0;
  logic [2:0] state0;
  logic [1:0] level0;
  logic [2:0] hp0;
  logic [3:0] min0, s10_0, s1_0, wl0;
  logic       tk0;

  logic       st1 = 0, pa1 = 0, go1 = 0, dm1 = 0, he1 = 0;
  logic [2:0] state1;
  logic [1:0] level1;
  logic [2:0] hp1;
  logic [3:0] min1, s10_1, s1_1, wl1;
  logic       tk1;

  int n_chk = 0;
  int n_err = 0;

  game_flow_ctrl #(
    .TICK_DIV(4), .START_MIN(4), .START_SEC(44), .WAIT_SEC(3),
    .MAX_HP(3), .HP_W(3), .NUM_LEVELS(2), .LVL_W(2)
  ) u0 (
    .clk(clk), .rst(rst), .start(st0), .pause(pa0), .goal(go0),
    .damage(dm0), .heal(he0), .state(state0), .level(level0), .hp(hp0),
    .t_min(min0), .t_sec10(s10_0), .t_sec1(s1_0), .wait_left(wl0),
    .sec_tick(tk0)
  );

  game_flow_ctrl #(
    .TICK_DIV(2), .START_MIN(1), .START_SEC(10), .WAIT_SEC(1),
    .MAX_HP(3), .HP_W(3), .NUM_LEVELS(3), .LVL_W(2)
  ) u1 (
    .clk(clk), .rst(rst), .start(st1), .pause(pa1), .goal(go1),
    .damage(dm1), .heal(he1), .state(state1), .level(level1), .hp(hp1),
    .t_min(min1), .t_sec10(s10_1), .t_sec1(s1_1), .wait_left(wl1),
    .sec_tick(tk1)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_time0(input string tag, input int m, input int s10, input int s1);
    chk({tag, ".min"}, int'(min0), m);
    chk({tag, ".sec10"}, int'(s10_0), s10);
    chk({tag, ".sec1"}, int'(s1_0), s1);
  endtask

  task automatic chk_time1(input string tag, input int m, input int s10, input int s1);
    chk({tag, ".min"}, int'(min1), m);
    chk({tag, ".sec10"}, int'(s10_1), s10);
    chk({tag, ".sec1"}, int'(s1_1), s1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(2);
    chk("rst.state", int'(state0), 0);
    chk("rst.level", int'(level0), 0);
    chk("rst.hp", int'(hp0), 3);
    chk_time0("rst.time0", 4, 4, 4);
    chk("rst.wait", int'(wl0), 3);
    chk("rst.tick", int'(tk0), 0);
    chk_time1("rst.time1", 1, 1, 0);
    rst = 1'b0;
    cyc(1);

    dm0 = 1; cyc(1); dm0 = 0;
    chk("init.damage_ign.hp", int'(hp0), 3);
    chk("init.damage_ign.state", int'(state0), 0);

    // Instance 1: 1:10 countdown, two cycles per second
    st1 = 1; cyc(1); st1 = 0;
    chk("u1.wait.state", int'(state1), 1);
    cyc(2);
    chk("u1.game.state", int'(state1), 2);
    chk_time1("u1.game.time", 1, 1, 0);
    cyc(20);
    chk_time1("u1.1m00", 1, 0, 0);
    cyc(2);
    chk_time1("u1.0m59", 0, 5, 9);
    chk("u1.0m59.tick", int'(tk1), 1);
    cyc(98);
    chk_time1("u1.0m10", 0, 1, 0);
    cyc(2);
    chk_time1("u1.0m09", 0, 0, 9);
    cyc(18);
    chk_time1("u1.0m00", 0, 0, 0);
    chk("u1.0m00.state", int'(state1), 2);
    cyc(1);
    chk("u1.lose.state", int'(state1), 4);
    cyc(3);
    chk_time1("u1.nowrap", 0, 0, 0);
    chk("u1.lose.held", int'(state1), 4);

    // Instance 0: wait countdown into GAME
    st0 = 1; cyc(1); st0 = 0;
    chk("u0.wait.state", int'(state0), 1);
    chk("u0.wait.left3", int'(wl0), 3);
    cyc(3);
    chk("u0.wait.left3b", int'(wl0), 3);
    chk("u0.wait.notick", int'(tk0), 0);
    cyc(1);
    chk("u0.wait.left2", int'(wl0), 2);
    chk("u0.wait.tick", int'(tk0), 1);
    dm0 = 1; he0 = 1; pa0 = 1; cyc(4); dm0 = 0; he0 = 0; pa0 = 0;
    chk("u0.wait.left1", int'(wl0), 1);
    chk("u0.wait.ign.hp", int'(hp0), 3);
    cyc(3);
    chk("u0.wait.still", int'(state0), 1);
    cyc(1);
    chk("u0.game.state", int'(state0), 2);
    chk("u0.game.wait0", int'(wl0), 0);
    chk_time0("u0.game.time", 4, 4, 4);

    // Pause with the prescaler at 2, long hold, resume
    cyc(2);
    pa0 = 1; cyc(1); pa0 = 0;
    chk("u0.pause.state", int'(state0), 5);
    dm0 = 1; cyc(50); dm0 = 0;
    chk("u0.pause.hp", int'(hp0), 3);
    chk("u0.pause.state2", int'(state0), 5);
    chk_time0("u0.pause.time", 4, 4, 4);
    pa0 = 1; cyc(1); pa0 = 0;
    chk("u0.resume.state", int'(state0), 2);
    cyc(1);
    chk("u0.resume.notick", int'(tk0), 0);
    chk("u0.resume.sec1", int'(s1_0), 4);
    cyc(1);
    chk("u0.resume.tick", int'(tk0), 1);
    chk_time0("u0.resume.time", 4, 4, 3);

    // hp saturation and simultaneous damage/heal
    he0 = 1; cyc(1); he0 = 0;
    chk("u0.heal.sat", int'(hp0), 3);
    he0 = 1; dm0 = 1; cyc(1); he0 = 0; dm0 = 0;
    chk("u0.both.hp", int'(hp0), 3);
    dm0 = 1; cyc(1);
    chk("u0.dmg.hp2", int'(hp0), 2);
    cyc(1); dm0 = 0;
    chk("u0.dmg.hp1", int'(hp0), 1);

    // Goal with a fatal damage: goal wins, level advances, hp kept
    go0 = 1; dm0 = 1; cyc(1); go0 = 0; dm0 = 0;
    chk("u0.goal.state", int'(state0), 1);
    chk("u0.goal.level", int'(level0), 1);
    chk("u0.goal.hp", int'(hp0), 1);
    chk("u0.goal.wait", int'(wl0), 3);
    chk_time0("u0.goal.time", 4, 4, 4);
    cyc(12);
    chk("u0.lvl1.game", int'(state0), 2);
    go0 = 1; dm0 = 1; cyc(1); go0 = 0; dm0 = 0;
    chk("u0.win.state", int'(state0), 3);
    chk("u0.win.hp", int'(hp0), 1);
    cyc(2);
    chk("u0.win.held", int'(state0), 3);
    chk("u0.win.level", int'(level0), 1);

    // Restart from WIN, then lose by damage
    st0 = 1; cyc(1); st0 = 0;
    chk("u0.restart.state", int'(state0), 1);
    chk("u0.restart.level", int'(level0), 0);
    chk("u0.restart.hp", int'(hp0), 3);
    cyc(12);
    chk("u0.regame.state", int'(state0), 2);
    dm0 = 1; cyc(3); dm0 = 0;
    chk("u0.dmg3.hp", int'(hp0), 0);
    chk("u0.dmg3.state", int'(state0), 2);
    cyc(1);
    chk("u0.dmg3.lose", int'(state0), 4);
    he0 = 1; cyc(1); he0 = 0;
    chk("u0.lose.hp_held", int'(hp0), 0);

    // Asynchronous reset mid-operation
    st0 = 1; cyc(3); st0 = 0;
    rst = 1'b1;
    #1;
    chk("arst.state", int'(state0), 0);
    chk("arst.hp", int'(hp0), 3);
    chk("arst.wait", int'(wl0), 3);
    chk_time1("arst.time1", 1, 1, 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
